// File: rtl/cpu_pkg.sv
// Shared definitions for the MIPS pipeline: immediate-extension encodings,
// ALU opcodes and the control bundle carried from ID into EX.
package cpu_pkg;

    localparam int ALU_OPW = 4;

    // Immediate extension selector; the fourth code is reserved and behaves as zero-extend
    typedef enum logic [1:0] {
        EXT_ZERO = 2'b00,
        EXT_SIGN = 2'b01,
        EXT_LUI  = 2'b10,
        EXT_RSVD = 2'b11
    } ext_op_e;

    // ALU operation encodings understood by the EX stage
    localparam logic [ALU_OPW-1:0] ALU_ADD = 4'h0;
    localparam logic [ALU_OPW-1:0] ALU_SUB = 4'h1;
    localparam logic [ALU_OPW-1:0] ALU_AND = 4'h2;
    localparam logic [ALU_OPW-1:0] ALU_OR  = 4'h3;
    localparam logic [ALU_OPW-1:0] ALU_XOR = 4'h4;
    localparam logic [ALU_OPW-1:0] ALU_NOR = 4'h5;
    localparam logic [ALU_OPW-1:0] ALU_SLT = 4'h6;
    localparam logic [ALU_OPW-1:0] ALU_SLL = 4'h7;
    localparam logic [ALU_OPW-1:0] ALU_SRL = 4'h8;
    localparam logic [ALU_OPW-1:0] ALU_SRA = 4'h9;
    localparam logic [ALU_OPW-1:0] ALU_LUI = 4'hA;

    // Control bits that travel alongside the instruction into EX
    typedef struct packed {
        logic [ALU_OPW-1:0] alu_op;
        logic               alu_src;
        logic               reg_write;
        logic               mem_read;
        logic               mem_write;
        logic               mem_to_reg;
    } ctrl_t;

    // A bubble must never write registers or touch memory
    localparam ctrl_t BUBBLE = '0;

endpackage

// File: rtl/imm_ext.sv
// 16-bit immediate extension: zero, sign or LUI placement into 32 bits.
module imm_ext
    import cpu_pkg::*;
(
    input  logic [15:0] imm16,
    input  logic [1:0]  ext_op,
    output logic [31:0] imm32
);

    // Pick the extension form; the reserved code falls back to zero-extend
    always_comb begin
        imm32 = {16'b0, imm16};
        case (ext_op)
            EXT_SIGN: imm32 = {{16{imm16[15]}}, imm16};
            EXT_LUI:  imm32 = {imm16, 16'b0};
            default:  imm32 = {16'b0, imm16};
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register. Captures operands, register addresses, the
// extended immediate and control for EX, with stall (hold) and flush (bubble).
// Operands are bypassed from WB on load and refreshed from WB while held so a
// stalled instruction never carries stale register data.
module id_ex_stage
    import cpu_pkg::*;
#(
    parameter int DW     = 32,
    parameter int AW     = 5,
    parameter int ALUOPW = ALU_OPW
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [DW-1:0]     id_pc,
    input  logic [DW-1:0]     id_rs_data,
    input  logic [DW-1:0]     id_rt_data,
    input  logic [15:0]       id_imm16,
    input  logic [AW-1:0]     id_rs,
    input  logic [AW-1:0]     id_rt,
    input  logic [AW-1:0]     id_rd,
    input  logic [1:0]        id_ext_op,
    input  logic [ALUOPW-1:0] id_alu_op,
    input  logic              id_alu_src,
    input  logic              id_reg_dst,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_mem_to_reg,
    input  logic              stall,
    input  logic              flush,
    input  logic              wb_we,
    input  logic [AW-1:0]     wb_waddr,
    input  logic [DW-1:0]     wb_wdata,
    output logic              ex_valid,
    output logic [DW-1:0]     ex_pc,
    output logic [DW-1:0]     ex_rs_data,
    output logic [DW-1:0]     ex_rt_data,
    output logic [DW-1:0]     ex_imm,
    output logic [AW-1:0]     ex_rs,
    output logic [AW-1:0]     ex_rt,
    output logic [AW-1:0]     ex_wreg,
    output logic [ALUOPW-1:0] ex_alu_op,
    output logic              ex_alu_src,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_mem_to_reg
);

    logic [31:0] id_imm32;
    ctrl_t       id_ctrl;
    ctrl_t       ex_ctrl;
    logic        wb_hit;
    logic        byp_rs;
    logic        byp_rt;
    logic        ref_rs;
    logic        ref_rt;

    imm_ext u_imm_ext (
        .imm16  (id_imm16),
        .ext_op (id_ext_op),
        .imm32  (id_imm32)
    );

    // Build the incoming control bundle; an invalid ID slot may not write or touch memory
    always_comb begin
        id_ctrl            = BUBBLE;
        id_ctrl.alu_op     = id_alu_op;
        id_ctrl.alu_src    = id_alu_src;
        id_ctrl.reg_write  = id_reg_write & id_valid;
        id_ctrl.mem_read   = id_mem_read  & id_valid;
        id_ctrl.mem_write  = id_mem_write & id_valid;
        id_ctrl.mem_to_reg = id_mem_to_reg;
    end

    // WB forwarding matches: load-time bypass against ID addresses, hold-time refresh against EX addresses; $0 never matches
    always_comb begin
        wb_hit = wb_we && (wb_waddr != '0);
        byp_rs = wb_hit && (wb_waddr == id_rs);
        byp_rt = wb_hit && (wb_waddr == id_rt);
        ref_rs = ex_valid && wb_hit && (wb_waddr == ex_rs);
        ref_rt = ex_valid && wb_hit && (wb_waddr == ex_rt);
    end

    // Pipeline register with priority flush > stall > load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid   <= 1'b0;
            ex_pc      <= '0;
            ex_rs_data <= '0;
            ex_rt_data <= '0;
            ex_imm     <= '0;
            ex_rs      <= '0;
            ex_rt      <= '0;
            ex_wreg    <= '0;
            ex_ctrl    <= BUBBLE;
        end else if (flush) begin
            ex_valid   <= 1'b0;
            ex_pc      <= '0;
            ex_rs_data <= '0;
            ex_rt_data <= '0;
            ex_imm     <= '0;
            ex_rs      <= '0;
            ex_rt      <= '0;
            ex_wreg    <= '0;
            ex_ctrl    <= BUBBLE;
        end else if (stall) begin
            if (ref_rs) begin
                ex_rs_data <= wb_wdata;
            end
            if (ref_rt) begin
                ex_rt_data <= wb_wdata;
            end
        end else begin
            ex_valid   <= id_valid;
            ex_pc      <= id_pc;
            ex_rs_data <= byp_rs ? wb_wdata : id_rs_data;
            ex_rt_data <= byp_rt ? wb_wdata : id_rt_data;
            ex_imm     <= id_imm32;
            ex_rs      <= id_rs;
            ex_rt      <= id_rt;
            ex_wreg    <= id_reg_dst ? id_rd : id_rt;
            ex_ctrl    <= id_ctrl;
        end
    end

    assign ex_alu_op     = ex_ctrl.alu_op;
    assign ex_alu_src    = ex_ctrl.alu_src;
    assign ex_reg_write  = ex_ctrl.reg_write;
    assign ex_mem_read   = ex_ctrl.mem_read;
    assign ex_mem_write  = ex_ctrl.mem_write;
    assign ex_mem_to_reg = ex_ctrl.mem_to_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage: reset, immediate extension, stall with
// WB refresh, flush priority, load bypass, invalid-slot gating, back-to-back.
module tb_id_ex_stage;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_rs_data;
    logic [31:0] id_rt_data;
    logic [15:0] id_imm16;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic [1:0]  id_ext_op;
    logic [3:0]  id_alu_op;
    logic        id_alu_src;
    logic        id_reg_dst;
    logic        id_reg_write;
    logic        id_mem_read;
    logic        id_mem_write;
    logic        id_mem_to_reg;
    logic        stall;
    logic        flush;
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [31:0] ex_rs_data;
    logic [31:0] ex_rt_data;
    logic [31:0] ex_imm;
    logic [4:0]  ex_rs;
    logic [4:0]  ex_rt;
    logic [4:0]  ex_wreg;
    logic [3:0]  ex_alu_op;
    logic        ex_alu_src;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_mem_to_reg;

    int total;
    int bad;

    id_ex_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_valid      (id_valid),
        .id_pc         (id_pc),
        .id_rs_data    (id_rs_data),
        .id_rt_data    (id_rt_data),
        .id_imm16      (id_imm16),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_rd         (id_rd),
        .id_ext_op     (id_ext_op),
        .id_alu_op     (id_alu_op),
        .id_alu_src    (id_alu_src),
        .id_reg_dst    (id_reg_dst),
        .id_reg_write  (id_reg_write),
        .id_mem_read   (id_mem_read),
        .id_mem_write  (id_mem_write),
        .id_mem_to_reg (id_mem_to_reg),
        .stall         (stall),
        .flush         (flush),
        .wb_we         (wb_we),
        .wb_waddr      (wb_waddr),
        .wb_wdata      (wb_wdata),
        .ex_valid      (ex_valid),
        .ex_pc         (ex_pc),
        .ex_rs_data    (ex_rs_data),
        .ex_rt_data    (ex_rt_data),
        .ex_imm        (ex_imm),
        .ex_rs         (ex_rs),
        .ex_rt         (ex_rt),
        .ex_wreg       (ex_wreg),
        .ex_alu_op     (ex_alu_op),
        .ex_alu_src    (ex_alu_src),
        .ex_reg_write  (ex_reg_write),
        .ex_mem_read   (ex_mem_read),
        .ex_mem_write  (ex_mem_write),
        .ex_mem_to_reg (ex_mem_to_reg)
    );

    // 10-time-unit clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        id_valid      = 1'b0;
        id_pc         = '0;
        id_rs_data    = '0;
        id_rt_data    = '0;
        id_imm16      = '0;
        id_rs         = '0;
        id_rt         = '0;
        id_rd         = '0;
        id_ext_op     = 2'b00;
        id_alu_op     = '0;
        id_alu_src    = 1'b0;
        id_reg_dst    = 1'b0;
        id_reg_write  = 1'b0;
        id_mem_read   = 1'b0;
        id_mem_write  = 1'b0;
        id_mem_to_reg = 1'b0;
        stall         = 1'b0;
        flush         = 1'b0;
        wb_we         = 1'b0;
        wb_waddr      = '0;
        wb_wdata      = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        #2;
        total++;
        if ({ex_valid, ex_pc, ex_rs_data, ex_imm, ex_reg_write} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_initial: got valid=%b pc=%h rs_data=%h imm=%h", ex_valid, ex_pc, ex_rs_data, ex_imm);
        end
        rst_n = 1'b1;
        step();
        id_valid = 1'b1; id_pc = 32'h40; id_rs_data = 32'h1234; id_rt_data = 32'h5678;
        id_imm16 = 16'h0009; id_rs = 5'd2; id_rt = 5'd3; id_rd = 5'd4; id_reg_dst = 1'b1;
        id_reg_write = 1'b1; id_mem_write = 1'b1; id_alu_op = 4'h3;
        step();
        total++;
        if (ex_valid !== 1'b1 || ex_pc !== 32'h40 || ex_wreg !== 5'd4) begin
            bad++;
            $display("[TB] FAIL reset_preload: got valid=%b pc=%h wreg=%0d want 1 00000040 4", ex_valid, ex_pc, ex_wreg);
        end
        stall = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({ex_valid, ex_pc, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_wreg, ex_alu_op,
             ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_async: got valid=%b pc=%h rs_data=%h wreg=%0d reg_write=%b want all 0", ex_valid, ex_pc, ex_rs_data, ex_wreg, ex_reg_write);
        end
        #1;
        rst_n = 1'b1;
        clear_inputs();
        step();
    endtask

    task automatic test_imm_ext();
        logic [31:0] expect_imm [4];
        expect_imm[0] = 32'h00008001;
        expect_imm[1] = 32'hFFFF8001;
        expect_imm[2] = 32'h80010000;
        expect_imm[3] = 32'h00008001;
        clear_inputs();
        id_valid = 1'b1;
        id_imm16 = 16'h8001;
        for (int i = 0; i < 4; i++) begin
            id_ext_op = 2'(i);
            step();
            total++;
            if (ex_imm !== expect_imm[i]) begin
                bad++;
                $display("[TB] FAIL imm_ext_op%0d: got %h want %h", i, ex_imm, expect_imm[i]);
            end
        end
    endtask

    task automatic test_stall_refresh();
        clear_inputs();
        id_valid = 1'b1; id_pc = 32'h100; id_rs = 5'd5; id_rs_data = 32'h11;
        id_rt = 5'd6; id_rt_data = 32'h22; id_imm16 = 16'h0004; id_ext_op = 2'b01;
        id_reg_write = 1'b1; id_alu_op = 4'h1;
        step();
        total++;
        if (ex_rs_data !== 32'h11 || ex_rt_data !== 32'h22) begin
            bad++;
            $display("[TB] FAIL stall_load: got rs_data=%h rt_data=%h want 11 22", ex_rs_data, ex_rt_data);
        end
        id_pc = 32'hDEAD; id_rs = 5'd9; id_rs_data = 32'h55; id_rt_data = 32'h66; id_imm16 = 16'h7777;
        id_reg_write = 1'b0;
        stall = 1'b1; wb_we = 1'b1; wb_waddr = 5'd5; wb_wdata = 32'hAB;
        step();
        total++;
        if (ex_rs_data !== 32'hAB) begin
            bad++;
            $display("[TB] FAIL stall_refresh_rs: got %h want 000000ab", ex_rs_data);
        end
        total++;
        if (ex_pc !== 32'h100 || ex_rt_data !== 32'h22 || ex_rs !== 5'd5 || ex_imm !== 32'h4 ||
            ex_valid !== 1'b1 || ex_reg_write !== 1'b1 || ex_alu_op !== 4'h1) begin
            bad++;
            $display("[TB] FAIL stall_hold: got pc=%h rt_data=%h rs=%0d imm=%h valid=%b rw=%b", ex_pc, ex_rt_data, ex_rs, ex_imm, ex_valid, ex_reg_write);
        end
        wb_waddr = 5'd6; wb_wdata = 32'hBEEF;
        step();
        total++;
        if (ex_rt_data !== 32'hBEEF || ex_rs_data !== 32'hAB) begin
            bad++;
            $display("[TB] FAIL stall_refresh_rt: got rt_data=%h rs_data=%h want 0000beef 000000ab", ex_rt_data, ex_rs_data);
        end
        wb_waddr = 5'd0; wb_wdata = 32'hCD;
        step();
        total++;
        if (ex_rs_data !== 32'hAB || ex_rt_data !== 32'hBEEF) begin
            bad++;
            $display("[TB] FAIL stall_r0_nochange: got rs_data=%h rt_data=%h", ex_rs_data, ex_rt_data);
        end
        clear_inputs();
        id_valid = 1'b1; id_rs = 5'd0; id_rs_data = 32'h0; id_rt = 5'd8; id_rt_data = 32'h88;
        wb_we = 1'b1; wb_waddr = 5'd0; wb_wdata = 32'h77;
        step();
        total++;
        if (ex_rs_data !== 32'h0) begin
            bad++;
            $display("[TB] FAIL bypass_r0: got %h want 00000000", ex_rs_data);
        end
        stall = 1'b1;
        step();
        total++;
        if (ex_rs_data !== 32'h0 || ex_rt_data !== 32'h88) begin
            bad++;
            $display("[TB] FAIL refresh_r0: got rs_data=%h rt_data=%h want 0 88", ex_rs_data, ex_rt_data);
        end
    endtask

    task automatic test_flush();
        clear_inputs();
        id_valid = 1'b1; id_pc = 32'h300; id_rs = 5'd1; id_rs_data = 32'h31;
        id_reg_write = 1'b1; id_mem_write = 1'b1;
        step();
        total++;
        if (ex_valid !== 1'b1 || ex_reg_write !== 1'b1 || ex_mem_write !== 1'b1) begin
            bad++;
            $display("[TB] FAIL flush_preload: got valid=%b rw=%b mw=%b want 1 1 1", ex_valid, ex_reg_write, ex_mem_write);
        end
        stall = 1'b1; flush = 1'b1;
        step();
        total++;
        if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_mem_write !== 1'b0 ||
            ex_mem_read !== 1'b0 || ex_pc !== 32'h0 || ex_rs_data !== 32'h0) begin
            bad++;
            $display("[TB] FAIL flush_over_stall: got valid=%b rw=%b mw=%b pc=%h rs_data=%h want all 0", ex_valid, ex_reg_write, ex_mem_write, ex_pc, ex_rs_data);
        end
    endtask

    task automatic test_load_bypass();
        clear_inputs();
        id_valid = 1'b1; id_rs = 5'd3; id_rs_data = 32'h33; id_rt = 5'd7; id_rt_data = 32'h1;
        wb_we = 1'b1; wb_waddr = 5'd7; wb_wdata = 32'h99;
        step();
        total++;
        if (ex_rt_data !== 32'h99 || ex_rs_data !== 32'h33) begin
            bad++;
            $display("[TB] FAIL load_bypass: got rt_data=%h rs_data=%h want 99 33", ex_rt_data, ex_rs_data);
        end
        wb_waddr = 5'd3; wb_wdata = 32'h44; id_rt_data = 32'h2;
        step();
        total++;
        if (ex_rs_data !== 32'h44 || ex_rt_data !== 32'h2) begin
            bad++;
            $display("[TB] FAIL load_bypass_rs: got rs_data=%h rt_data=%h want 44 2", ex_rs_data, ex_rt_data);
        end
        clear_inputs();
        id_valid = 1'b0; id_reg_write = 1'b1; id_mem_read = 1'b1; id_mem_write = 1'b1;
        step();
        total++;
        if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_mem_read !== 1'b0 || ex_mem_write !== 1'b0) begin
            bad++;
            $display("[TB] FAIL invalid_gating: got valid=%b rw=%b mr=%b mw=%b want 0 0 0 0", ex_valid, ex_reg_write, ex_mem_read, ex_mem_write);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] pcs  [3];
        logic [4:0]  rds  [3];
        logic [4:0]  rts  [3];
        logic        dsts [3];
        logic [4:0]  wants[3];
        pcs[0] = 32'h200; pcs[1] = 32'h204; pcs[2] = 32'h208;
        rds[0] = 5'd10;   rds[1] = 5'd11;   rds[2] = 5'd12;
        rts[0] = 5'd20;   rts[1] = 5'd21;   rts[2] = 5'd22;
        dsts[0] = 1'b1;   dsts[1] = 1'b0;   dsts[2] = 1'b1;
        wants[0] = 5'd10; wants[1] = 5'd21; wants[2] = 5'd12;
        clear_inputs();
        for (int i = 0; i < 3; i++) begin
            id_valid = 1'b1; id_pc = pcs[i]; id_rd = rds[i]; id_rt = rts[i];
            id_reg_dst = dsts[i]; id_alu_op = 4'(i + 2); id_alu_src = i[0];
            id_mem_to_reg = ~i[0]; id_reg_write = 1'b1;
            step();
            total++;
            if (ex_pc !== pcs[i] || ex_wreg !== wants[i] || ex_valid !== 1'b1 ||
                ex_alu_op !== 4'(i + 2) || ex_alu_src !== i[0] || ex_mem_to_reg !== ~i[0]) begin
                bad++;
                $display("[TB] FAIL back_to_back_%0d: got pc=%h wreg=%0d alu_op=%h want pc=%h wreg=%0d alu_op=%h", i, ex_pc, ex_wreg, ex_alu_op, pcs[i], wants[i], 4'(i + 2));
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_imm_ext();
        test_stall_refresh();
        test_flush();
        test_load_bypass();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
